// File: rtl/onekiwi_pkg.sv
// rtl/onekiwi_pkg.sv - shared opcode, ALU source and width definitions for onekiwi_cpu
package onekiwi_pkg;

    localparam int KIWI_AW = 4;
    localparam int KIWI_DW = 8;

    typedef enum logic [3:0] {
        OP_ADD_A  = 4'h0,
        OP_MOV_AB = 4'h1,
        OP_IN_A   = 4'h2,
        OP_MOV_AI = 4'h3,
        OP_MOV_BA = 4'h4,
        OP_ADD_B  = 4'h5,
        OP_IN_B   = 4'h6,
        OP_MOV_BI = 4'h7,
        OP_OUT_B  = 4'h9,
        OP_OUT_I  = 4'hB,
        OP_HLT    = 4'hD,
        OP_JNC    = 4'hE,
        OP_JMP    = 4'hF
    } opcode_e;

    localparam logic [1:0] SRC_A    = 2'd0;
    localparam logic [1:0] SRC_B    = 2'd1;
    localparam logic [1:0] SRC_IN   = 2'd2;
    localparam logic [1:0] SRC_ZERO = 2'd3;

endpackage

// File: rtl/ifetch_decode_decoder.sv
// rtl/ifetch_decode_decoder.sv - combinational opcode decoder (instr_decoder)
module instr_decoder
    import onekiwi_pkg::*;
(
    input  logic [3:0] op,
    input  logic       carry_q,
    output logic [1:0] src_sel,
    output logic       ld_a,
    output logic       ld_b,
    output logic       ld_out,
    output logic       jump_raw,
    output logic       is_add,
    output logic       is_hlt
);

    always_comb begin
        src_sel  = SRC_ZERO;
        ld_a     = 1'b0;
        ld_b     = 1'b0;
        ld_out   = 1'b0;
        jump_raw = 1'b0;
        is_add   = 1'b0;
        is_hlt   = 1'b0;
        case (opcode_e'(op))
            OP_ADD_A:  begin src_sel = SRC_A;    ld_a = 1'b1; is_add = 1'b1; end
            OP_MOV_AB: begin src_sel = SRC_B;    ld_a = 1'b1; end
            OP_IN_A:   begin src_sel = SRC_IN;   ld_a = 1'b1; end
            OP_MOV_AI: begin src_sel = SRC_ZERO; ld_a = 1'b1; end
            OP_MOV_BA: begin src_sel = SRC_A;    ld_b = 1'b1; end
            OP_ADD_B:  begin src_sel = SRC_B;    ld_b = 1'b1; is_add = 1'b1; end
            OP_IN_B:   begin src_sel = SRC_IN;   ld_b = 1'b1; end
            OP_MOV_BI: begin src_sel = SRC_ZERO; ld_b = 1'b1; end
            OP_OUT_B:  begin src_sel = SRC_B;    ld_out = 1'b1; end
            OP_OUT_I:  begin src_sel = SRC_ZERO; ld_out = 1'b1; end
            OP_HLT:    is_hlt = 1'b1;
            OP_JNC:    jump_raw = ~carry_q;
            OP_JMP:    jump_raw = 1'b1;
            default:   ;
        endcase
    end

endmodule

// File: rtl/ifetch_decode.sv
// rtl/ifetch_decode.sv - program store, decode, carry/halt state and retired counter
module ifetch_decode
    import onekiwi_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = KIWI_AW,
    parameter int DW    = KIWI_DW,
    parameter int CNTW  = 8
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic [AW-1:0]   adr,
    input  logic            prog_mode,
    input  logic            prog_we,
    input  logic [AW-1:0]   prog_adr,
    input  logic [DW-1:0]   prog_data,
    input  logic            alu_carry,
    output logic            jump,
    output logic [AW-1:0]   jump_tgt,
    output logic [3:0]      imm,
    output logic [1:0]      src_sel,
    output logic            ld_a,
    output logic            ld_b,
    output logic            ld_out,
    output logic            carry_q,
    output logic            halted,
    output logic [CNTW-1:0] retired
);

    logic [DW-1:0]   mem_q [DEPTH];
    logic [DW-1:0]   instr;
    logic            halted_q, halted_d;
    logic            carry_d;
    logic [CNTW-1:0] retired_q, retired_d;
    logic            exec;
    logic            dec_ld_a, dec_ld_b, dec_ld_out, jump_raw, is_add, is_hlt;

    // Asynchronous read: a same-cycle write to adr is only seen after the edge.
    assign instr = mem_q[adr];
    assign imm   = instr[3:0];
    assign exec  = ~prog_mode & ~halted_q;

    instr_decoder u_dec (
        .op       (instr[DW-1:DW-4]),
        .carry_q  (carry_q),
        .src_sel  (src_sel),
        .ld_a     (dec_ld_a),
        .ld_b     (dec_ld_b),
        .ld_out   (dec_ld_out),
        .jump_raw (jump_raw),
        .is_add   (is_add),
        .is_hlt   (is_hlt)
    );

    // Programming forces pc to 0; halt parks pc on the current address.
    always_comb begin
        jump     = jump_raw;
        jump_tgt = AW'(instr[3:0]);
        ld_a     = dec_ld_a;
        ld_b     = dec_ld_b;
        ld_out   = dec_ld_out;
        if (prog_mode) begin
            jump     = 1'b1;
            jump_tgt = '0;
            ld_a     = 1'b0;
            ld_b     = 1'b0;
            ld_out   = 1'b0;
        end else if (halted_q) begin
            jump     = 1'b1;
            jump_tgt = adr;
            ld_a     = 1'b0;
            ld_b     = 1'b0;
            ld_out   = 1'b0;
        end
    end

    always_comb begin
        carry_d   = carry_q;
        halted_d  = halted_q;
        retired_d = retired_q;
        if (exec) begin
            carry_d   = is_add & alu_carry;
            retired_d = retired_q + CNTW'(1);
            if (is_hlt) begin
                halted_d = 1'b1;
            end
        end
        if (prog_mode) begin
            halted_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            carry_q   <= 1'b0;
            halted_q  <= 1'b0;
            retired_q <= '0;
        end else begin
            carry_q   <= carry_d;
            halted_q  <= halted_d;
            retired_q <= retired_d;
            if (prog_mode && prog_we) begin
                mem_q[prog_adr] <= prog_data;
            end
        end
    end

    assign halted  = halted_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_ifetch_decode.sv
// tb/tb_ifetch_decode.sv - self-checking bench for ifetch_decode
module tb_ifetch_decode;
    import onekiwi_pkg::*;

    logic       clk = 1'b0;
    logic       nrst;
    logic [3:0] adr;
    logic       prog_mode;
    logic       prog_we;
    logic [3:0] prog_adr;
    logic [7:0] prog_data;
    logic       alu_carry;
    logic       jump;
    logic [3:0] jump_tgt;
    logic [3:0] imm;
    logic [1:0] src_sel;
    logic       ld_a, ld_b, ld_out;
    logic       carry_q;
    logic       halted;
    logic [7:0] retired;

    always #5 clk = ~clk;

    ifetch_decode dut (
        .clk       (clk),
        .nrst      (nrst),
        .adr       (adr),
        .prog_mode (prog_mode),
        .prog_we   (prog_we),
        .prog_adr  (prog_adr),
        .prog_data (prog_data),
        .alu_carry (alu_carry),
        .jump      (jump),
        .jump_tgt  (jump_tgt),
        .imm       (imm),
        .src_sel   (src_sel),
        .ld_a      (ld_a),
        .ld_b      (ld_b),
        .ld_out    (ld_out),
        .carry_q   (carry_q),
        .halted    (halted),
        .retired   (retired)
    );

    typedef struct {
        logic [7:0] instr;
        logic       ac;
        logic [1:0] src;
        logic       la, lb, lo;
        logic       jmp;
        logic       chk_src;
    } vec_t;

    typedef struct {
        logic [1:0] src;
        logic       la, lb, lo, jmp;
        logic [3:0] tgt, imm;
        logic       chk_src, chk_tgt;
    } exp_t;

    exp_t       sb[$];
    vec_t       tbl[18];
    int         n_pass = 0;
    int         n_total = 0;

    logic [7:0] mem_m [16];
    logic       carry_m, halted_m;
    logic [7:0] retired_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
        carry_m = 1'b0;
        halted_m = 1'b0;
        retired_m = 8'd0;
    endtask

    // Reference model advances with the same inputs the DUT sees at the edge.
    task automatic tick();
        logic [3:0] op;
        op = mem_m[adr][7:4];
        if (!prog_mode && !halted_m) begin
            carry_m = (op == 4'h0 || op == 4'h5) ? alu_carry : 1'b0;
            retired_m = retired_m + 8'd1;
            if (op == 4'hD) halted_m = 1'b1;
        end
        if (prog_mode) halted_m = 1'b0;
        if (prog_mode && prog_we) mem_m[prog_adr] = prog_data;
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".carry_q"}, carry_q, carry_m);
        chk({tag, ".halted"}, halted, halted_m);
        chk({tag, ".retired"}, retired, retired_m);
    endtask

    task automatic prog_write(input logic [3:0] a, input logic [7:0] d);
        prog_mode = 1'b1;
        prog_we   = 1'b1;
        prog_adr  = a;
        prog_data = d;
        tick();
        prog_we   = 1'b0;
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 1, 0);
            return;
        end
        e = sb.pop_front();
        chk({tag, ".ld_a"}, ld_a, e.la);
        chk({tag, ".ld_b"}, ld_b, e.lb);
        chk({tag, ".ld_out"}, ld_out, e.lo);
        chk({tag, ".jump"}, jump, e.jmp);
        chk({tag, ".imm"}, imm, e.imm);
        if (e.chk_src) chk({tag, ".src"}, src_sel, e.src);
        if (e.chk_tgt) chk({tag, ".tgt"}, jump_tgt, e.tgt);
    endtask

    initial begin
        exp_t e;
        logic [7:0] rsave;
        logic [7:0] n;

        tbl[0]  = '{8'h03, 1'b1, SRC_A,    1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{8'hE9, 1'b0, SRC_A,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{8'hE9, 1'b1, SRC_A,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{8'h5A, 1'b1, SRC_B,    1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{8'hE2, 1'b0, SRC_A,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{8'h12, 1'b1, SRC_B,    1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{8'h24, 1'b1, SRC_IN,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{8'h3C, 1'b0, SRC_ZERO, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{8'h41, 1'b0, SRC_A,    1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{8'h66, 1'b0, SRC_IN,   1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{8'h7F, 1'b0, SRC_ZERO, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{8'h90, 1'b0, SRC_B,    1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[12] = '{8'hB5, 1'b0, SRC_ZERO, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[13] = '{8'h8C, 1'b0, SRC_A,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{8'hA1, 1'b0, SRC_A,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{8'hC7, 1'b0, SRC_A,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[16] = '{8'hF3, 1'b0, SRC_A,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[17] = '{8'h0E, 1'b0, SRC_A,    1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

        nrst = 1'b0; adr = 4'd0; prog_mode = 1'b0; prog_we = 1'b0;
        prog_adr = 4'd0; prog_data = 8'h00; alu_carry = 1'b0;
        model_reset();
        #3;
        chk("rst.halted", halted, 1'b0);
        chk("rst.carry", carry_q, 1'b0);
        chk("rst.retired", retired, 8'd0);
        chk("rst.ld_a", ld_a, 1'b1);
        chk("rst.src", src_sel, SRC_A);
        chk("rst.jump", jump, 1'b0);

        prog_mode = 1'b1;
        nrst = 1'b1;
        prog_write(4'd0, 8'h37);
        prog_write(4'd1, 8'hF0);
        prog_mode = 1'b0;
        adr = 4'd0;
        #2;
        chk("t2.ld_a", ld_a, 1'b1);
        chk("t2.src", src_sel, SRC_ZERO);
        chk("t2.imm", imm, 4'd7);
        tick();
        adr = 4'd1;
        #2;
        chk("t2.jump", jump, 1'b1);
        chk("t2.tgt", jump_tgt, 4'd0);
        tick();
        chk("t2.retired", retired, 8'd2);
        check_regs("t2");

        for (int i = 0; i < 18; i++) begin
            prog_write(4'd5, tbl[i].instr);
            prog_mode = 1'b0;
            adr = 4'd5;
            alu_carry = tbl[i].ac;
            e.src = tbl[i].src; e.la = tbl[i].la; e.lb = tbl[i].lb; e.lo = tbl[i].lo;
            e.jmp = tbl[i].jmp; e.tgt = tbl[i].instr[3:0]; e.imm = tbl[i].instr[3:0];
            e.chk_src = tbl[i].chk_src; e.chk_tgt = tbl[i].jmp;
            sb.push_back(e);
            #2;
            check_out($sformatf("vec%0d", i));
            tick();
            check_regs($sformatf("vec%0d", i));
        end

        alu_carry = 1'b0;
        prog_write(4'd4, 8'hD0);
        prog_mode = 1'b0;
        adr = 4'd4;
        #2;
        chk("hlt.pre_jump", jump, 1'b0);
        chk("hlt.pre_ld", {ld_a, ld_b, ld_out}, 3'b000);
        tick();
        chk("hlt.halted", halted, 1'b1);
        chk("hlt.jump", jump, 1'b1);
        chk("hlt.tgt", jump_tgt, 4'd4);
        adr = 4'd9;
        #2;
        chk("hlt.tgt_adr", jump_tgt, 4'd9);
        chk("hlt.ld", {ld_a, ld_b, ld_out}, 3'b000);
        rsave = retired_m;
        repeat (10) tick();
        chk("hlt.retired_frozen", retired, rsave);
        check_regs("hlt");
        prog_mode = 1'b1;
        #2;
        chk("prog.jump", jump, 1'b1);
        chk("prog.tgt", jump_tgt, 4'd0);
        tick();
        chk("prog.halt_clear", halted, 1'b0);
        adr = 4'd4;
        tick();
        chk("hlt_prog.halted", halted, 1'b0);
        check_regs("hlt_prog");

        prog_write(4'd3, 8'h7F);
        prog_mode = 1'b0;
        adr = 4'd3;
        prog_we = 1'b1; prog_adr = 4'd3; prog_data = 8'h90;
        #2;
        chk("we_ign.pre_ld_b", ld_b, 1'b1);
        tick();
        prog_we = 1'b0;
        #2;
        chk("we_ign.ld_b", ld_b, 1'b1);
        chk("we_ign.imm", imm, 4'hF);
        prog_mode = 1'b1; prog_we = 1'b1;
        #2;
        chk("we_same.old_imm", imm, 4'hF);
        tick();
        prog_we = 1'b0;
        #2;
        chk("we_same.new_imm", imm, 4'h0);
        prog_mode = 1'b0;
        #2;
        chk("we_same.ld_out", ld_out, 1'b1);
        chk("we_same.src", src_sel, SRC_B);

        adr = 4'd0;
        n = 8'd255 - retired_m;
        repeat (n) tick();
        chk("wrap.255", retired, 8'd255);
        tick();
        chk("wrap.0", retired, 8'd0);
        adr = 4'd4;
        tick();
        chk("arst.pre_halted", halted, 1'b1);
        #2;
        nrst = 1'b0;
        #1;
        model_reset();
        check_regs("arst");
        chk("arst.ld_a", ld_a, 1'b1);
        chk("arst.jump", jump, 1'b0);
        adr = 4'd0;
        #1;
        chk("arst.mem0_imm", imm, 4'd0);
        chk("arst.mem0_src", src_sel, SRC_A);
        #1;
        nrst = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
